// File: rtl/bcp_pkg.sv
// Shared types and helpers for the BCP unit-clause sequencer.
package bcp_pkg;

  // Sequencer states; IDLE must encode as zero so reset lands there.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PICK  = 3'd1,
    ST_OFFER = 3'd2,
    ST_DONE  = 3'd3,
    ST_CONFL = 3'd4
  } state_e;

  // Widest vector the lowest-set-bit helper can scan.
  localparam int PE_MAX_W = 64;

  // Width of a variable index; never narrower than one bit.
  function automatic int idx_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

  // Width of a counter that must reach w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int lowest_set(input logic [PE_MAX_W-1:0] v);
    int r;
    r = 0;
    for (int i = PE_MAX_W - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lsb_pe.sv
// Lowest-index priority encoder: reports the smallest set bit of vec.
module lsb_pe
  import bcp_pkg::*;
#(
  parameter  int W     = 4,
  localparam int IDX_W = idx_width(W)
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [PE_MAX_W-1:0] vec_ext_s;

  // Zero-extend into the helper's scan width and encode; idx is 0 when empty.
  always_comb begin
    vec_ext_s          = '0;
    vec_ext_s[W-1:0]   = vec;
    idx                = IDX_W'(lowest_set(vec_ext_s));
    any                = |vec;
  end

endmodule

// File: rtl/unit_prop_sched.sv
// Unit-clause sequencer: holds pending unit literals, emits them lowest
// index first over valid/ready, merges implied literals and flags
// polarity conflicts.
module unit_prop_sched
  import bcp_pkg::*;
#(
  parameter  int W     = 4,
  localparam int IDX_W = idx_width(W),
  localparam int CNT_W = cnt_width(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     load_vec,
  input  logic [W-1:0]     load_pol,
  input  logic             imp_valid,
  input  logic [W-1:0]     imp_vec,
  input  logic [W-1:0]     imp_pol,
  input  logic             abort,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_pol,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             conflict,
  output logic [IDX_W-1:0] conf_idx,
  output logic [CNT_W-1:0] assign_cnt
);

  state_e           state_q, state_d;
  logic [W-1:0]     pending_q, pending_d;
  logic [W-1:0]     pol_q, pol_d;
  logic [W-1:0]     assigned_q, assigned_d;
  logic [W-1:0]     apol_q, apol_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic             cur_pol_q, cur_pol_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             conflict_q, conflict_d;
  logic [IDX_W-1:0] conf_idx_q, conf_idx_d;

  logic             merge_act_s;
  logic             conf_hit_s;
  logic [W-1:0]     conf_vec_s;
  logic [W-1:0]     new_vec_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_any_s;
  logic [IDX_W-1:0] conf_lo_s;
  logic             conf_any_s;

  // Next variable to emit: lowest pending index.
  lsb_pe #(.W(W)) u_pick_pe (
    .vec (pending_q),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // Lowest variable whose implied polarity contradicts a held literal.
  lsb_pe #(.W(W)) u_conf_pe (
    .vec (conf_vec_s),
    .idx (conf_lo_s),
    .any (conf_any_s)
  );

  // Classify the implied-literal strobe against the registered sets.
  always_comb begin
    merge_act_s = 1'b0;
    if (imp_valid && ((state_q == ST_PICK) || (state_q == ST_OFFER))) begin
      merge_act_s = 1'b1;
    end else begin
      merge_act_s = 1'b0;
    end
    // A contradiction can hit either a still-pending or an already-assigned variable.
    conf_vec_s = imp_vec & ((pending_q  & (pol_q  ^ imp_pol)) |
                            (assigned_q & (apol_q ^ imp_pol)));
    // Only unseen variables join the pending set; this also keeps the
    // variable being picked right now from being re-pended.
    new_vec_s  = imp_vec & ~pending_q & ~assigned_q;
    conf_hit_s = merge_act_s & conf_any_s;
  end

  // Next-state and register update logic.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    pol_d      = pol_q;
    assigned_d = assigned_q;
    apol_d     = apol_q;
    cur_idx_d  = cur_idx_q;
    cur_pol_d  = cur_pol_q;
    cnt_d      = cnt_q;
    conflict_d = conflict_q;
    conf_idx_d = conf_idx_q;

    if (abort) begin
      // Flush the run; the emitted count stays visible until the next start.
      state_d    = ST_IDLE;
      pending_d  = '0;
      assigned_d = '0;
      cur_idx_d  = '0;
      cur_pol_d  = 1'b0;
      conflict_d = 1'b0;
      conf_idx_d = '0;
    end else if (conf_hit_s) begin
      // A conflict freezes everything else this cycle, including a handshake.
      state_d    = ST_CONFL;
      conflict_d = 1'b1;
      conf_idx_d = conf_lo_s;
    end else begin
      if (merge_act_s) begin
        pending_d = pending_q | new_vec_s;
        pol_d     = (pol_q & ~new_vec_s) | (imp_pol & new_vec_s);
      end else begin
        pending_d = pending_q;
        pol_d     = pol_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pending_d  = load_vec;
            pol_d      = load_pol;
            assigned_d = '0;
            cnt_d      = '0;
            state_d    = ST_PICK;
          end else begin
            state_d    = ST_IDLE;
          end
        end
        ST_PICK: begin
          if (pick_any_s) begin
            cur_idx_d              = pick_idx_s;
            cur_pol_d              = pol_q[pick_idx_s];
            pending_d[pick_idx_s]  = 1'b0;
            assigned_d[pick_idx_s] = 1'b1;
            apol_d[pick_idx_s]     = pol_q[pick_idx_s];
            cnt_d                  = cnt_q + CNT_W'(1);
            state_d                = ST_OFFER;
          end else if (merge_act_s && (|new_vec_s)) begin
            // Fresh literals arrived while empty: the set has not drained.
            state_d = ST_PICK;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_OFFER: begin
          if (out_ready) begin
            state_d = ST_PICK;
          end else begin
            state_d = ST_OFFER;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        ST_CONFL: begin
          state_d = ST_CONFL;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      pol_q      <= '0;
      assigned_q <= '0;
      apol_q     <= '0;
      cur_idx_q  <= '0;
      cur_pol_q  <= 1'b0;
      cnt_q      <= '0;
      conflict_q <= 1'b0;
      conf_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      pol_q      <= pol_d;
      assigned_q <= assigned_d;
      apol_q     <= apol_d;
      cur_idx_q  <= cur_idx_d;
      cur_pol_q  <= cur_pol_d;
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
      conf_idx_q <= conf_idx_d;
    end
  end

  // Outputs decode directly from registers; the offered literal reads as 0 when not valid.
  always_comb begin
    out_valid  = (state_q == ST_OFFER);
    if (state_q == ST_OFFER) begin
      out_idx = cur_idx_q;
      out_pol = cur_pol_q;
    end else begin
      out_idx = '0;
      out_pol = 1'b0;
    end
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    conflict   = conflict_q;
    conf_idx   = conf_idx_q;
    assign_cnt = cnt_q;
  end

endmodule
